// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, PC step and reset PC.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t WAIT  = 2'd1;
    localparam fetch_state_t HOLD  = 2'd2;
    localparam fetch_state_t FAULT = 2'd3;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stats.sv
// Fetch performance counters: accepted instructions and cycles spent fetching or waiting.
// Only instantiated when FETCH_STATS_EN is defined.
module fetch_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            if (fetch_inc) fetch_count_q <= fetch_count_q + 32'd1;
            if (stall_inc) stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with flush redirect and misaligned-PC fault.
// Define FETCH_STATS_EN to add the FetchCount/StallCount performance outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] NextPC,
    input  logic        Flush,
    input  logic [31:0] FlushPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic        InstValid,
    output logic [31:0] Inst,
    output logic [31:0] InstPC,
    output logic [31:0] PC4,
    input  logic        InstReady,
    output logic        Fault
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         drop_q, drop_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        drop_d    = drop_q;

        // A response that arrives while drop is set belongs to an abandoned request.
        if (IMemRValid && drop_q) drop_d = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (Flush) begin
                    pc_d    = FlushPC;
                    state_d = pc_aligned(FlushPC) ? FETCH : FAULT;
                end else if (IMemReq && IMemGnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (Flush) begin
                    pc_d    = FlushPC;
                    state_d = pc_aligned(FlushPC) ? FETCH : FAULT;
                    if (!IMemRValid) drop_d = 1'b1;
                end else if (IMemRValid && !drop_q) begin
                    inst_d    = IMemRData;
                    inst_pc_d = pc_q;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (Flush) begin
                    pc_d    = FlushPC;
                    state_d = pc_aligned(FlushPC) ? FETCH : FAULT;
                end else if (InstReady) begin
                    pc_d    = NextPC;
                    state_d = pc_aligned(NextPC) ? FETCH : FAULT;
                end
            end
            FAULT: begin
                if (Flush && pc_aligned(FlushPC)) begin
                    pc_d    = FlushPC;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            // Keep discarding a response still in flight from before (or during) reset.
            drop_q    <= ((state_q == WAIT) || drop_q) && !IMemRValid;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            drop_q    <= drop_d;
        end
    end

    // Hold off a new request until any stale response has drained.
    assign IMemReq   = Reset && (state_q == FETCH) && !drop_q;
    assign IMemAddr  = pc_q;
    assign InstValid = (state_q == HOLD);
    assign Inst      = inst_q;
    assign InstPC    = inst_pc_q;
    assign PC4       = inst_pc_q + PC_INC;
    assign Fault     = (state_q == FAULT);

`ifdef FETCH_STATS_EN
    logic fetch_inc;
    logic stall_inc;

    // A flush in the handshake cycle wins, so that instruction is not counted.
    assign fetch_inc = InstValid && InstReady && !Flush;
    assign stall_inc = (state_q == FETCH) || (state_q == WAIT);

    fetch_stats u_fetch_stats (
        .clk         (CLK),
        .reset       (Reset),
        .fetch_inc   (fetch_inc),
        .stall_inc   (stall_inc),
        .fetch_count (FetchCount),
        .stall_count (StallCount)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory model plus directed decode traffic.
module tb_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [31:0] NextPC;
    logic        Flush;
    logic [31:0] FlushPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        InstValid;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic [31:0] PC4;
    logic        InstReady;
    logic        Fault;
`ifdef FETCH_STATS_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    fetch_unit #(.RESET_PC(32'h00000000)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .NextPC     (NextPC),
        .Flush      (Flush),
        .FlushPC    (FlushPC),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemGnt    (IMemGnt),
        .IMemRValid (IMemRValid),
        .IMemRData  (IMemRData),
        .InstValid  (InstValid),
        .Inst       (Inst),
        .InstPC     (InstPC),
        .PC4        (PC4),
        .InstReady  (InstReady),
        .Fault      (Fault)
`ifdef FETCH_STATS_EN
        ,
        .FetchCount (FetchCount),
        .StallCount (StallCount)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        expq[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int          lat      = 1;
    bit          gnt_en   = 1'b1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr;
    logic [31:0] gaddr;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h20080005;
        return {a[15:0], 16'hC0DE} ^ 32'h00000101;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = memword(pc);
        expq.push_back(e);
    endtask

    // Wait for a held instruction, score it, optionally stall, then hand it off.
    task automatic take(input int hold, input logic [31:0] nxt, input bit fl,
                        input logic [31:0] flpc, output int waited);
        exp_t        e;
        logic [31:0] held;
        waited = 0;
        while (!InstValid && waited < 30) begin
            step();
            waited++;
        end
        if (!InstValid) begin
            check("inst_timeout", 32'(InstValid), 32'd1);
            return;
        end
        if (expq.size() == 0) begin
            check("sb_empty", 32'(expq.size()), 32'd1);
            return;
        end
        e = expq.pop_front();
        check("inst", Inst, e.inst);
        check("inst_pc", InstPC, e.pc);
        check("pc4", PC4, e.pc + 32'd4);
        held = Inst;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 32'(InstValid), 32'd1);
            check("hold_inst", Inst, held);
            check("hold_noreq", 32'(IMemReq), 32'd0);
        end
        NextPC    = nxt;
        Flush     = fl;
        FlushPC   = flpc;
        InstReady = 1'b1;
        step();
        InstReady = 1'b0;
        Flush     = 1'b0;
    endtask

    // Memory model: grants at the coming edge, responds lat cycles after the grant.
    initial begin
        IMemGnt    = 1'b0;
        IMemRValid = 1'b0;
        IMemRData  = 32'd0;
        forever begin
            @(negedge CLK);
            if (IMemGnt) begin
                pend_addr = gaddr;
                pend_cnt  = lat;
            end
            IMemRValid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    IMemRValid = 1'b1;
                    IMemRData  = memword(pend_addr);
                end
            end
            IMemGnt = IMemReq && gnt_en && !Flush && Reset;
            gaddr   = IMemAddr;
        end
    end

    initial begin
        int w;
        Reset     = 1'b0;
        NextPC    = 32'd0;
        Flush     = 1'b0;
        FlushPC   = 32'd0;
        InstReady = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(InstValid), 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        check("rst_req", 32'(IMemReq), 32'd0);
        check("rst_inst", Inst, 32'd0);
        check("rst_instpc", InstPC, 32'd0);

        Reset = 1'b1;
        #1;
        check("first_req", 32'(IMemReq), 32'd1);
        check("first_addr", IMemAddr, 32'd0);
        expect_inst(32'h0);
        take(5, 32'h40, 1'b0, 32'h0, w);
        check("first_latency", 32'(w), 32'd2);
        check("next_addr", IMemAddr, 32'h40);
        check("next_req", 32'(IMemReq), 32'd1);
        check("next_novalid", 32'(InstValid), 32'd0);

        // Flush while waiting; the old response lands two cycles later.
        expect_inst(32'h40);
        take(0, 32'h44, 1'b0, 32'h0, w);
        lat = 3;
        step();
        check("wait_noreq", 32'(IMemReq), 32'd0);
        Flush   = 1'b1;
        FlushPC = 32'h100;
        step();
        Flush = 1'b0;
        lat   = 1;
        for (int i = 0; i < 10 && !IMemReq; i++) begin
            check("flush_novalid", 32'(InstValid), 32'd0);
            step();
        end
        check("flush_req", 32'(IMemReq), 32'd1);
        check("flush_addr", IMemAddr, 32'h100);
        expect_inst(32'h100);

        // Flush and handshake together: the flush target wins.
        take(0, 32'h8, 1'b1, 32'h200, w);
        check("fl_hs_addr", IMemAddr, 32'h200);
        check("fl_hs_novalid", 32'(InstValid), 32'd0);
        expect_inst(32'h200);
        take(0, 32'h42, 1'b0, 32'h0, w);
        check("mis_fault", 32'(Fault), 32'd1);
        check("mis_noreq", 32'(IMemReq), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fault_hold", 32'(Fault), 32'd1);
            check("fault_noreq", 32'(IMemReq), 32'd0);
        end
        Flush   = 1'b1;
        FlushPC = 32'h0;
        step();
        Flush = 1'b0;
        check("unfault", 32'(Fault), 32'd0);
        check("unfault_req", 32'(IMemReq), 32'd1);
        check("unfault_addr", IMemAddr, 32'h0);

        // PC4 wrap and a misaligned flush target.
        expect_inst(32'h0);
        take(0, 32'hFFFFFFFC, 1'b0, 32'h0, w);
        expect_inst(32'hFFFFFFFC);
        while (!InstValid && w < 30) begin
            step();
            w++;
        end
        check("pc4_wrap", PC4, 32'h0);
        take(0, 32'h0, 1'b1, 32'h102, w);
        check("flush_mis_fault", 32'(Fault), 32'd1);
        Flush   = 1'b1;
        FlushPC = 32'h10;
        step();
        Flush = 1'b0;
        check("refetch_addr", IMemAddr, 32'h10);

        // Flush in FETCH while the request is being held off.
        gnt_en = 1'b0;
        step();
        step();
        check("ungranted_req", 32'(IMemReq), 32'd1);
        check("ungranted_addr", IMemAddr, 32'h10);
        Flush   = 1'b1;
        FlushPC = 32'h300;
        gnt_en  = 1'b1;
        step();
        Flush = 1'b0;
        check("fetch_flush_addr", IMemAddr, 32'h300);
        check("fetch_flush_req", 32'(IMemReq), 32'd1);
        expect_inst(32'h300);
        take(0, 32'h10, 1'b0, 32'h0, w);

        // Reset while waiting; the stale response must not surface.
        lat = 3;
        step();
        check("rw_wait_noreq", 32'(IMemReq), 32'd0);
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        lat   = 1;
        expect_inst(32'h0);
        take(0, 32'h4, 1'b0, 32'h0, w);
        Reset = 1'b0;

`ifdef FETCH_STATS_EN
        lat = 2;
        step();
        step();
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_inst(32'(i * 4));
            take(0, 32'((i + 1) * 4), 1'b0, 32'h0, w);
        end
        check("fetch_count", FetchCount, 32'd4);
        check("stall_count", StallCount, 32'd12);
`else
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
